// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the PC fetch unit.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_PF,
        S_PFW,
        S_FULL,
        S_DROP
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction/PC holding buffer for a prefetch response that
// returned while decode was stalled.
module fetch_skid_buf #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] wpc,
    input  logic            rd,
    input  logic            flush,
    output logic            valid,
    output logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] rpc
);

    logic            valid_q;
    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (wr) begin
            valid_q <= 1'b1;
        end else if (rd || flush) begin
            valid_q <= 1'b0;
        end
    end

    // Payload needs no reset: it is only observed while valid_q is set.
    always_ff @(posedge clk) begin
        if (wr) begin
            data_q <= wdata;
            pc_q   <= wpc;
        end
    end

    assign valid = valid_q;
    assign rdata = data_q;
    assign rpc   = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch with one speculative prefetch.
// Define FETCH_PERF_CNT_EN to add the perf_fetched/perf_squashed/perf_stall counters.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            pcsrc,
    input  logic [XLEN-1:0] imm_ext
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_squashed,
    output logic [31:0]     perf_stall
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            instr_valid_q, instr_valid_d;

    logic            hs, acc, redirect;
    logic [XLEN-1:0] target;
    logic            buf_wr, buf_rd, buf_flush, buf_valid;
    logic [XLEN-1:0] buf_data, buf_pc;
    logic            delivered, squashed;

    // Gated by rst so no request is visible while reset is held.
    assign imem_req_valid = ((state_q == S_REQ) || (state_q == S_PF)) && !rst;
    assign imem_addr      = fetch_pc_q;
    assign hs             = imem_req_valid && imem_req_ready;
    assign acc            = instr_valid_q && instr_ready;
    assign redirect       = acc && pcsrc;
    assign target         = instr_pc_q + imm_ext;

    fetch_skid_buf #(
        .XLEN (XLEN)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .wr    (buf_wr),
        .wdata (imem_rdata),
        .wpc   (req_pc_q),
        .rd    (buf_rd),
        .flush (buf_flush),
        .valid (buf_valid),
        .rdata (buf_data),
        .rpc   (buf_pc)
    );

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q && !acc;
        buf_wr        = 1'b0;
        buf_rd        = 1'b0;
        buf_flush     = 1'b0;
        delivered     = 1'b0;
        squashed      = 1'b0;

        if (redirect) begin
            fetch_pc_d = target;
        end else if (hs) begin
            fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
        end
        if (hs) begin
            req_pc_d = fetch_pc_q;
        end

        unique case (state_q)
            S_REQ: begin
                if (hs) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = req_pc_q;
                    instr_valid_d = 1'b1;
                    delivered     = 1'b1;
                    state_d       = S_PF;
                end
            end
            S_PF: begin
                if (acc) begin
                    if (pcsrc) state_d = hs ? S_DROP : S_REQ;
                    else       state_d = hs ? S_WAIT : S_REQ;
                end else if (hs) begin
                    state_d = S_PFW;
                end
            end
            S_PFW: begin
                if (acc && pcsrc) begin
                    if (imem_rsp_valid) begin
                        squashed = 1'b1;
                        state_d  = S_REQ;
                    end else begin
                        state_d  = S_DROP;
                    end
                end else if (acc) begin
                    if (imem_rsp_valid) begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = req_pc_q;
                        instr_valid_d = 1'b1;
                        delivered     = 1'b1;
                        state_d       = S_PF;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (imem_rsp_valid) begin
                    buf_wr  = 1'b1;
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (acc && pcsrc) begin
                    buf_flush = 1'b1;
                    squashed  = 1'b1;
                    state_d   = S_REQ;
                end else if (acc && buf_valid) begin
                    instr_d       = buf_data;
                    instr_pc_d    = buf_pc;
                    instr_valid_d = 1'b1;
                    buf_rd        = 1'b1;
                    delivered     = 1'b1;
                    state_d       = S_PF;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    squashed = 1'b1;
                    state_d  = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            fetch_pc_q    <= XLEN'(RESET_PC);
            req_pc_q      <= XLEN'(RESET_PC);
            instr_q       <= XLEN'(NOP_INSTR);
            instr_pc_q    <= XLEN'(RESET_PC);
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q, squashed_q, stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q  <= '0;
            squashed_q <= '0;
            stall_q    <= '0;
        end else begin
            if (delivered)      fetched_q  <= fetched_q + 32'd1;
            if (squashed)       squashed_q <= squashed_q + 32'd1;
            if (!instr_valid_q) stall_q    <= stall_q + 32'd1;
        end
    end

    assign perf_fetched  = fetched_q;
    assign perf_squashed = squashed_q;
    assign perf_stall    = stall_q;
`else
    logic unused_perf;
    assign unused_perf = delivered ^ squashed;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: scripted decode behaviour against a
// single-outstanding imem responder with programmable latency.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        pcsrc;
    logic [31:0] imm_ext;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_squashed, perf_stall;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int          rsp_lat;
    logic [31:0] rsp_addr;

    pc_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .XLEN     (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pcsrc          (pcsrc),
        .imm_ext        (imm_ext)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_squashed  (perf_squashed),
        .perf_stall     (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0: return 32'h0010_0093;
            32'h4: return 32'h0020_0113;
            32'h8: return 32'h0030_0193;
            default: return {16'hABCD, a[15:0]};
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Responder: handshake seen at negedge, data returned rsp_lat cycles later for one cycle.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rdata     = '0;
        forever begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready && !rst) begin
                rsp_addr = imem_addr;
                for (int i = 1; i < rsp_lat; i++) @(posedge clk);
                @(posedge clk);
                #1;
                imem_rsp_valid = 1'b1;
                imem_rdata     = mem_word(rsp_addr);
                @(posedge clk);
                #1;
                imem_rsp_valid = 1'b0;
            end
        end
    end

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        pcsrc          = 1'b0;
        imm_ext        = '0;
        rsp_lat        = 1;

        repeat (3) tick();
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", instr, 32'h0000_0013);
        check_eq("rst_instr_pc", instr_pc, 32'h0);
        rst = 1'b0;
        #1;
        check_eq("first_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("first_addr", imem_addr, 32'h0);

        // Straight line, decode always ready once the first instr lands.
        tick();
        check_eq("wait_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("wait_instr_valid", 32'(instr_valid), 32'd0);
        tick();
        check_eq("i0_valid", 32'(instr_valid), 32'd1);
        check_eq("i0_pc", instr_pc, 32'h0);
        check_eq("i0_instr", instr, 32'h0010_0093);
        check_eq("pf0_addr", imem_addr, 32'h4);
        instr_ready = 1'b1;
        tick();
        check_eq("post_acc_valid", 32'(instr_valid), 32'd0);
        tick();
        check_eq("i1_pc", instr_pc, 32'h4);
        check_eq("i1_instr", instr, 32'h0020_0113);
        tick();
        check_eq("post_acc1_valid", 32'(instr_valid), 32'd0);
        tick();
        check_eq("i2_pc", instr_pc, 32'h8);
        check_eq("i2_instr", instr, 32'h0030_0193);

        // Taken branch while prefetch of 0xC is outstanding.
        instr_ready = 1'b0;
        rsp_lat     = 2;
        tick();
        check_eq("pfw_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("pfw_instr_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        pcsrc       = 1'b1;
        imm_ext     = 32'hFFFF_FFF8;
        tick();
        instr_ready = 1'b0;
        pcsrc       = 1'b0;
        imm_ext     = '0;
        check_eq("drop_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("drop_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        check_eq("redir_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("redir_addr", imem_addr, 32'h0);
        check_eq("redir_instr_valid", 32'(instr_valid), 32'd0);
        tick();
        tick();
        check_eq("redir_wait_valid", 32'(instr_valid), 32'd0);
        tick();
        check_eq("redir_i_valid", 32'(instr_valid), 32'd1);
        check_eq("redir_i_pc", instr_pc, 32'h0);
        check_eq("redir_i_instr", instr, 32'h0010_0093);

        // Taken branch in the same cycle the prefetch response arrives.
        rsp_lat = 1;
        tick();
        check_eq("pfw2_req_valid", 32'(imem_req_valid), 32'd0);
        instr_ready = 1'b1;
        pcsrc       = 1'b1;
        imm_ext     = 32'h0000_0020;
        tick();
        instr_ready = 1'b0;
        pcsrc       = 1'b0;
        imm_ext     = '0;
        check_eq("same_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("same_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("same_addr", imem_addr, 32'h20);
        tick();
        tick();
        check_eq("tgt_pc", instr_pc, 32'h20);
        check_eq("tgt_instr", instr, 32'hABCD_0020);

        // Reset while the prefetch of 0x24 is outstanding; its response arrives late.
        rsp_lat = 4;
        tick();
        check_eq("pfw3_req_valid", 32'(imem_req_valid), 32'd0);
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        tick();
        check_eq("mid_rst_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("mid_rst_instr", instr, 32'h0000_0013);
        check_eq("mid_rst_pc", instr_pc, 32'h0);
        check_eq("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_addr", imem_addr, 32'h0);
        repeat (3) tick();
        check_eq("late_rsp_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("late_rsp_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("late_rsp_addr", imem_addr, 32'h0);
        imem_req_ready = 1'b1;
        rsp_lat        = 1;
        tick();
        check_eq("refetch_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        check_eq("refetch_pc", instr_pc, 32'h0);
        check_eq("refetch_instr", instr, 32'h0010_0093);

        // Decode stalls four cycles; prefetch lands in the skid buffer.
        tick();
        check_eq("stall_pfw_req", 32'(imem_req_valid), 32'd0);
        tick();
        check_eq("full_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("full_instr_pc", instr_pc, 32'h0);
        tick();
        tick();
        check_eq("full_hold_req", 32'(imem_req_valid), 32'd0);
        check_eq("full_hold_instr", instr, 32'h0010_0093);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_eq("buf_out_valid", 32'(instr_valid), 32'd1);
        check_eq("buf_out_pc", instr_pc, 32'h4);
        check_eq("buf_out_instr", instr, 32'h0020_0113);
        check_eq("buf_out_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("buf_out_addr", imem_addr, 32'h8);
        tick();
        check_eq("final_pfw_req", 32'(imem_req_valid), 32'd0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
